// File: rtl/phase_sequencer.sv
// phase_sequencer: multicycle CPU control sequencer.
// Steps each instruction through FETCH -> EXEC (OP_CYCLES deep) -> [MEM] -> WRITEBACK,
// with mem_ready wait states, an optional memory timeout, halting only between
// instructions, and a count of retired instructions.
module phase_sequencer #(
  parameter int OP_CYCLES   = 2,
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ra_mux_cont,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             instruct_en,
  output logic             mem_en,
  output logic             ra_mux,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_count,
  output logic             halted,
  output logic             mem_err
);

  typedef enum logic [2:0] {
    S_FETCH = 3'b000,
    S_EXEC  = 3'b001,
    S_MEM   = 3'b010,
    S_WB    = 3'b011,
    S_HALT  = 3'b100,
    S_START = 3'b111
  } state_t;

  localparam int EW = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1;
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [EW-1:0] EXEC_LAST = EW'(OP_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit            TO_EN     = (MEM_TIMEOUT > 0);

  state_t           r_state;
  state_t           w_next;
  logic [EW-1:0]    r_exec_cnt;
  logic [WW-1:0]    r_wait_cnt;
  logic [CNT_W-1:0] r_retire;
  logic             r_mem_err;
  logic             w_timeout;
  logic             w_mem_wait;

  // A memory wait cycle: FETCH or MEM with no completion this cycle.
  assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;

  // Next-state and strobe decode; mem_ready always beats the timeout in the same cycle.
  always_comb begin
    w_next      = r_state;
    pc_en       = 1'b0;
    instruct_en = 1'b0;
    mem_en      = 1'b0;
    ra_mux      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_START: w_next = S_FETCH;
      S_FETCH: begin
        mem_en      = 1'b1;
        instruct_en = mem_ready;
        if (mem_ready) begin
          w_next = S_EXEC;
        end else if (TO_EN && (r_wait_cnt == WAIT_LAST)) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_EXEC: begin
        if (r_exec_cnt == EXEC_LAST) w_next = ra_mux_cont ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_en = 1'b1;
        ra_mux = 1'b1;
        if (mem_ready) begin
          w_next = S_WB;
        end else if (TO_EN && (r_wait_cnt == WAIT_LAST)) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_WB: begin
        pc_en  = 1'b1;
        mem_en = ra_mux_cont;
        ra_mux = ra_mux_cont;
        w_next = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (!r_mem_err && !halt_req) w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_START;
    else       r_state <= w_next;
  end

  // EXEC depth counter and memory wait counter; both clear whenever their phase ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exec_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_exec_cnt <= ((r_state == S_EXEC) && (r_exec_cnt != EXEC_LAST)) ? r_exec_cnt + 1'b1 : '0;
      r_wait_cnt <= (w_mem_wait && (w_next == r_state)) ? r_wait_cnt + 1'b1 : '0;
    end
  end

  // Retire counter (wraps) and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire  <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if (r_state == S_WB) r_retire <= r_retire + 1'b1;
      if (w_timeout)       r_mem_err <= 1'b1;
    end
  end

  assign state        = r_state;
  assign retire_count = r_retire;
  assign halted       = (r_state == S_HALT);
  assign mem_err      = r_mem_err;

endmodule

// File: tb/tb_phase_sequencer.sv
// Testbench for phase_sequencer: per-cycle expected traces built from instruction-level
// scenarios (fetch waits, memory access, memory waits, halt length), plus hand sequences
// for timeout, asynchronous reset and a single-cycle EXEC configuration.
module tb_phase_sequencer;

  localparam int OPC = 2;
  localparam int MT  = 4;
  localparam int CW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: OP_CYCLES=2, MEM_TIMEOUT=4, CNT_W=4
  logic          reset, rmc, rdy, hreq;
  logic          pc_en, ie, me, ra, halted, err;
  logic [2:0]    st;
  logic [CW-1:0] ret;

  phase_sequencer #(.OP_CYCLES(OPC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ra_mux_cont(rmc), .mem_ready(rdy), .halt_req(hreq),
    .pc_en(pc_en), .instruct_en(ie), .mem_en(me), .ra_mux(ra), .state(st),
    .retire_count(ret), .halted(halted), .mem_err(err)
  );

  // Second instance: OP_CYCLES=1, timeout disabled, CNT_W=8
  logic       rst1, rmc1, rdy1, hreq1;
  logic       pc_en1, ie1, me1, ra1, halted1, err1;
  logic [2:0] st1;
  logic [7:0] ret1;

  phase_sequencer #(.OP_CYCLES(1), .MEM_TIMEOUT(0), .CNT_W(8)) dut1 (
    .clk(clk), .reset(rst1), .ra_mux_cont(rmc1), .mem_ready(rdy1), .halt_req(hreq1),
    .pc_en(pc_en1), .instruct_en(ie1), .mem_en(me1), .ra_mux(ra1), .state(st1),
    .retire_count(ret1), .halted(halted1), .mem_err(err1)
  );

  typedef struct {
    logic       rmc, rdy, hreq;
    logic [2:0] st;
    logic       pc, ie, me, ra, hl, err;
    int         ret;
  } cyc_t;

  localparam logic [2:0] FE = 3'b000, EX = 3'b001, MM = 3'b010, WB = 3'b011, HL = 3'b100, SS = 3'b111;

  int   n_checks = 0;
  int   n_errors = 0;
  cyc_t q[$];
  int   m_ret;
  logic m_err;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic rbit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic push(input logic c_rmc, input logic c_rdy, input logic c_h, input logic [2:0] s,
                      input logic p, input logic i, input logic m, input logic a);
    cyc_t c;
    c.rmc = c_rmc; c.rdy = c_rdy; c.hreq = c_h; c.st = s;
    c.pc = p; c.ie = i; c.me = m; c.ra = a;
    c.hl = (s == HL); c.err = m_err; c.ret = m_ret;
    q.push_back(c);
  endtask

  // One instruction: fw fetch wait cycles, data access r, mw memory waits, hc halt cycles.
  task automatic push_instr(input int fw, input logic r, input int mw, input int hc);
    for (int k = 0; k < fw; k++) push(rbit(), 1'b0, rbit(), FE, 0, 0, 1, 0);
    push(rbit(), 1'b1, rbit(), FE, 0, 1, 1, 0);
    for (int k = 0; k < OPC; k++) push(r, rbit(), rbit(), EX, 0, 0, 0, 0);
    if (r) begin
      for (int k = 0; k < mw; k++) push(r, 1'b0, rbit(), MM, 0, 0, 1, 1);
      push(r, 1'b1, rbit(), MM, 0, 0, 1, 1);
    end
    push(r, rbit(), (hc > 0), WB, 1, 0, r, r);
    m_ret++;
    for (int k = 0; k < hc; k++) push(rbit(), rbit(), (k < hc - 1), HL, 0, 0, 0, 0);
  endtask

  task automatic run_q();
    foreach (q[k]) begin
      @(negedge clk);
      rmc = q[k].rmc; rdy = q[k].rdy; hreq = q[k].hreq;
      #1;
      check("state",        k, st,     q[k].st);
      check("pc_en",        k, pc_en,  q[k].pc);
      check("instruct_en",  k, ie,     q[k].ie);
      check("mem_en",       k, me,     q[k].me);
      check("ra_mux",       k, ra,     q[k].ra);
      check("halted",       k, halted, q[k].hl);
      check("mem_err",      k, err,    q[k].err);
      check("retire_count", k, ret,    q[k].ret % (1 << CW));
    end
    q.delete();
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_state"},   0, st,     SS);
    check({name, "_pc_en"},   0, pc_en,  1'b0);
    check({name, "_ie"},      0, ie,     1'b0);
    check({name, "_mem_en"},  0, me,     1'b0);
    check({name, "_ra_mux"},  0, ra,     1'b0);
    check({name, "_halted"},  0, halted, 1'b0);
    check({name, "_mem_err"}, 0, err,    1'b0);
    check({name, "_retire"},  0, ret,    0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    m_ret = 0;
    m_err = 1'b0;
  endtask

  cyc_t tbl[10];

  initial begin
    reset = 1'b0; rmc = 1'b0; rdy = 1'b0; hreq = 1'b0;
    rst1 = 1'b0; rmc1 = 1'b0; rdy1 = 1'b0; hreq1 = 1'b0;
    m_ret = 0; m_err = 1'b0;
    #2 reset = 1'b1; rst1 = 1'b1;

    // Zero-wait ALU instructions straight out of reset
    tbl[0] = '{rmc:0, rdy:1, hreq:0, st:SS, pc:0, ie:0, me:0, ra:0, hl:0, err:0, ret:0};
    tbl[1] = '{rmc:0, rdy:1, hreq:0, st:FE, pc:0, ie:1, me:1, ra:0, hl:0, err:0, ret:0};
    tbl[2] = '{rmc:0, rdy:1, hreq:0, st:EX, pc:0, ie:0, me:0, ra:0, hl:0, err:0, ret:0};
    tbl[3] = '{rmc:0, rdy:1, hreq:0, st:EX, pc:0, ie:0, me:0, ra:0, hl:0, err:0, ret:0};
    tbl[4] = '{rmc:0, rdy:1, hreq:0, st:WB, pc:1, ie:0, me:0, ra:0, hl:0, err:0, ret:0};
    tbl[5] = '{rmc:0, rdy:1, hreq:0, st:FE, pc:0, ie:1, me:1, ra:0, hl:0, err:0, ret:1};
    tbl[6] = '{rmc:0, rdy:1, hreq:0, st:EX, pc:0, ie:0, me:0, ra:0, hl:0, err:0, ret:1};
    tbl[7] = '{rmc:0, rdy:1, hreq:0, st:EX, pc:0, ie:0, me:0, ra:0, hl:0, err:0, ret:1};
    tbl[8] = '{rmc:0, rdy:1, hreq:0, st:WB, pc:1, ie:0, me:0, ra:0, hl:0, err:0, ret:1};
    tbl[9] = '{rmc:0, rdy:1, hreq:0, st:FE, pc:0, ie:1, me:1, ra:0, hl:0, err:0, ret:2};

    @(negedge clk); #1;
    check_reset_state("reset");
    release_reset();

    foreach (tbl[i]) q.push_back(tbl[i]);
    m_ret = 2;
    // tbl[9] was the ready FETCH of the next instruction; finish it as an ALU op
    for (int k = 0; k < OPC; k++) push(1'b0, rbit(), rbit(), EX, 0, 0, 0, 0);
    push(1'b0, rbit(), 1'b0, WB, 1, 0, 0, 0);
    m_ret++;
    // Load with 3 memory waits (ready lands on the timeout boundary), then a halt of 2 cycles
    push_instr(0, 1'b1, 3, 0);
    push_instr(0, 1'b0, 0, 2);
    // Randomized instruction mix; retire count wraps at 16
    for (int n = 0; n < 24; n++) begin
      push_instr($urandom_range(0, 3), rbit(), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    // Fetch timeout: 4 wait cycles, then HALT with sticky error regardless of halt_req
    for (int k = 0; k < MT; k++) push(rbit(), 1'b0, rbit(), FE, 0, 0, 1, 0);
    m_err = 1'b1;
    for (int k = 0; k < 3; k++) push(rbit(), rbit(), 1'b0, HL, 0, 0, 0, 0);
    run_q();
    check("retire_wrap", 0, ret, m_ret % (1 << CW));

    // Asynchronous reset while halted in error
    @(negedge clk);
    #3 reset = 1'b1;
    #1 check_reset_state("reset_err");
    release_reset();

    // Memory-phase timeout
    push(rbit(), rbit(), rbit(), SS, 0, 0, 0, 0);
    push_instr(1, 1'b1, 2, 0);
    push(rbit(), 1'b1, rbit(), FE, 0, 1, 1, 0);
    for (int k = 0; k < OPC; k++) push(1'b1, rbit(), rbit(), EX, 0, 0, 0, 0);
    for (int k = 0; k < MT; k++) push(1'b1, 1'b0, rbit(), MM, 0, 0, 1, 1);
    m_err = 1'b1;
    for (int k = 0; k < 2; k++) push(rbit(), rbit(), rbit(), HL, 0, 0, 0, 0);
    run_q();

    // Reset asserted in the middle of a MEM wait
    @(negedge clk);
    #3 reset = 1'b1;
    #1 reset = 1'b1;
    release_reset();
    push(rbit(), rbit(), rbit(), SS, 0, 0, 0, 0);
    push_instr(0, 1'b0, 0, 0);
    push(rbit(), 1'b1, rbit(), FE, 0, 1, 1, 0);
    for (int k = 0; k < OPC; k++) push(1'b1, rbit(), rbit(), EX, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) push(1'b1, 1'b0, rbit(), MM, 0, 0, 1, 1);
    run_q();
    @(negedge clk);
    rmc = 1'b1; rdy = 1'b0; hreq = 1'b0;
    #1;
    check("pre_reset_state",  0, st,  MM);
    check("pre_reset_mem_en", 0, me,  1'b1);
    check("pre_reset_retire", 0, ret, 1);
    #2 reset = 1'b1;
    #1;
    check_reset_state("reset_mem");
    release_reset();

    // Single-cycle EXEC instance: 3-cycle ALU instructions
    @(posedge clk);
    #2 rst1 = 1'b0;
    rdy1 = 1'b1; rmc1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      logic [2:0] es;
      @(negedge clk); #1;
      if (c == 0) es = SS;
      else if ((c - 1) % 3 == 0) es = FE;
      else if ((c - 1) % 3 == 1) es = EX;
      else es = WB;
      check("op1_state",  c, st1,    es);
      check("op1_pc_en",  c, pc_en1, (es == WB));
      check("op1_retire", c, ret1,   (c == 0) ? 0 : (c - 1) / 3);
    end
    // Long memory stall with the timeout disabled never flags an error
    @(negedge clk); rmc1 = 1'b1; rdy1 = 1'b1; #1;
    check("op1_fetch", 0, st1, FE);
    @(negedge clk); rdy1 = 1'b0; #1;
    check("op1_exec", 0, st1, EX);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      check("op1_mem_state", k, st1,  MM);
      check("op1_mem_en",    k, me1,  1'b1);
      check("op1_mem_err",   k, err1, 1'b0);
    end
    @(negedge clk); rdy1 = 1'b1; #1;
    check("op1_mem_done", 0, st1, MM);
    @(negedge clk); #1;
    check("op1_wb_state", 0, st1,    WB);
    check("op1_wb_pc_en", 0, pc_en1, 1'b1);
    check("op1_wb_ra",    0, ra1,    1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
